nf10_axis_pkt_checker: RTL and testbench
========================================

NF10_AXIS_PKT_CHECKER -- requirements
Module: nf10_axis_pkt_checker

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 64: slave tdata width, multiple of 8, 64..256.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128: tuser width; accepted and ignored.
REQ-003 SHALL have parameter C_PAYLOAD_WORDS, default 48: payload beats per packet, 1..256.
REQ-004 SHALL have parameter C_LAST_TSTRB, default 8'h3F: expected tstrb of the last beat, zero-extended to the tstrb width.
REQ-005 SHALL have parameter C_HDR0, default 64'hEFBEFECAFECAFECA: expected beat 0, zero-extended to the data width.
REQ-006 SHALL have parameter C_HDR1, default 64'h00000008EFBEEFBE: expected beat 1, zero-extended to the data width.
REQ-007 SHALL have parameter C_BACKPRESSURE, default 1: 1 = pseudo-random tready, 0 = tready held at 1.
REQ-008 axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-009 axi_resetn  in  1  reset, asynchronous, active-low.
REQ-010 s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  beat data.
REQ-011 s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
REQ-012 s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  unused.
REQ-013 s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1 (registered).
REQ-014 clear_stats  in  1  single-cycle pulse; zeroes both counters and err_flag.
REQ-015 pkt_count  out  32  number of packets received without error; err_count  out  32  number of errored packets.
REQ-016 err_flag  out  1  sticky error indication; err_code  out  3  cause of the most recent error.

Function
REQ-017 A beat SHALL transfer only when s_axis_tvalid and s_axis_tready are both 1 in the same cycle; a beat with tvalid=0 SHALL never be checked.
REQ-018 State machine SHALL have states HDR0, HDR1, PAYLOAD and DROP; the checker SHALL leave reset in HDR0.
REQ-019 HDR0: on a transfer, tdata must equal C_HDR0, tstrb all ones and tlast 0; on a pass the state SHALL go to HDR1.
REQ-020 HDR1: on a transfer, tdata must equal C_HDR1, tstrb all ones and tlast 0; on a pass the state SHALL go to PAYLOAD with the 8-bit beat counter at 0.
REQ-021 PAYLOAD: expected tdata SHALL be the beat counter replicated over all bytes.
REQ-022 PAYLOAD: for beat counter < C_PAYLOAD_WORDS-1, tstrb must be all ones and tlast 0; on a pass the counter SHALL increment.
REQ-023 PAYLOAD: at beat counter = C_PAYLOAD_WORDS-1, tstrb must equal C_LAST_TSTRB and tlast must be 1; on a pass pkt_count SHALL increment, the counter SHALL clear and the state SHALL go to HDR0.
REQ-024 Data SHALL be compared only on strobed bytes (tstrb bit = 1).
REQ-025 err_code values: 1 = header mismatch, 2 = payload data mismatch, 3 = tstrb mismatch, 4 = early tlast, 5 = missing tlast; when several apply, the lowest code SHALL be reported.
REQ-026 On any error: err_count SHALL increment, err_flag SHALL set and err_code SHALL load, all one cycle after the transfer.
REQ-027 After an error, if the errored beat had tlast=1 the state SHALL go to HDR0, otherwise to DROP.
REQ-028 DROP SHALL accept and discard beats without checking them, and SHALL go to HDR0 after the beat with tlast=1.
REQ-029 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-030 If clear_stats and a counter update fall in the same cycle, clear SHALL win; the packet state machine SHALL be unaffected by clear_stats.
REQ-031 With C_BACKPRESSURE=1, s_axis_tready SHALL be bit 0 of a 16-bit maximal-length LFSR, seed 16'hACE1, advancing every cycle.
REQ-032 With C_BACKPRESSURE=0, s_axis_tready SHALL be 1 from the first clock after reset release.

Reset
REQ-033 While axi_resetn=0, the checker SHALL hold: s_axis_tready=0, pkt_count=0, err_count=0, err_flag=0, err_code=0, state HDR0, beat counter 0, LFSR=16'hACE1.
REQ-034 Reset asserted mid-packet SHALL abandon the packet without counting it; checking SHALL restart at HDR0.

Structure
REQ-035 A shared package SHALL hold the state encoding, the err_code constants, the LFSR seed and the LFSR taps (16,14,13,11).
REQ-036 The LFSR SHALL be one sub-module, nf10_lfsr16, with ports clk, resetn, en and q[15:0].

Verification
REQ-037 Good packet (HDR0, HDR1, payload 0x00..0x2F; last beat tstrb 8'h3F with tlast), BACKPRESSURE=0 -> pkt_count=1, err_count=0, err_flag=0.
REQ-038 Payload beat 5 = 64'h0505050505050506 -> err_code=2, err_count=1; rest of packet dropped; next good packet -> pkt_count=1.
REQ-039 tlast asserted on payload beat 10 -> err_code=4; the next packet is checked from HDR0 and passes.
REQ-040 Last beat with tstrb=8'h3F but tlast=0, followed by 3 filler beats ending in tlast -> err_code=5; checker returns to HDR0 after the filler tlast.
REQ-041 BACKPRESSURE=1, 100 back-to-back good packets with source holding tvalid -> pkt_count=100, tready toggles, no beat lost.
REQ-042 clear_stats pulsed in the same cycle as a final beat -> both counters read 0 afterwards.

Source files
------------

// File: rtl/nf10_axis_pkt_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nf10_axis_pkt_checker_pkg
// Purpose  : Shared constants for the AXI-Stream packet checker: packet state
//            encoding, err_code values, LFSR seed/taps and the LFSR step
//            function.
// Revision : 1.0 - initial release
// ============================================================================
package nf10_axis_pkt_checker_pkg;

    // Packet state encoding
    localparam logic [1:0] c_st_hdr0    = 2'd0;
    localparam logic [1:0] c_st_hdr1    = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_drop    = 2'd3;

    // err_code values; lower value wins when several causes apply to a beat
    localparam logic [2:0] c_err_none         = 3'd0;
    localparam logic [2:0] c_err_hdr          = 3'd1;
    localparam logic [2:0] c_err_data         = 3'd2;
    localparam logic [2:0] c_err_strb         = 3'd3;
    localparam logic [2:0] c_err_early_last   = 3'd4;
    localparam logic [2:0] c_err_missing_last = 3'd5;

    // x^16 + x^14 + x^13 + x^11 + 1 : taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Fibonacci step: shift left, feedback parity enters at bit 0
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], ^(q & c_lfsr_taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : nf10_lfsr16
// Purpose  : 16-bit maximal-length Fibonacci LFSR, seeded on reset.
// Ports    : clk    - clock (rising edge)
//            resetn - asynchronous active-low reset, loads the seed
//            en     - advance one step per enabled cycle
//            q      - current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module nf10_lfsr16
    import nf10_axis_pkt_checker_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= c_lfsr_seed;
        end else if (en) begin
            r_q <= lfsr16_next(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/nf10_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// Module   : nf10_axis_pkt_checker
// Purpose  : AXI-Stream sink that checks fixed-format test packets
//            (two header beats, then C_PAYLOAD_WORDS payload beats whose bytes
//            all equal the beat index) and keeps good/errored packet counts.
// Ports    : axi_aclk/axi_resetn   - clock, async active-low reset
//            s_axis_*              - AXI-Stream slave (tuser ignored)
//            clear_stats           - pulse, zeroes counters and err_flag
//            pkt_count/err_count   - saturating good/errored packet counts
//            err_flag/err_code     - sticky error flag, cause of last error
// Revision : 1.0 - initial release
// ============================================================================
module nf10_axis_pkt_checker
    import nf10_axis_pkt_checker_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 64,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          C_PAYLOAD_WORDS      = 48,
    parameter logic [7:0]  C_LAST_TSTRB         = 8'h3F,
    parameter logic [63:0] C_HDR0               = 64'hEFBEFECAFECAFECA,
    parameter logic [63:0] C_HDR1               = 64'h00000008EFBEEFBE,
    parameter int          C_BACKPRESSURE       = 1
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic                              clear_stats,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       err_count,
    output logic                              err_flag,
    output logic [2:0]                        err_code
);

    localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;

    localparam logic [C_S_AXIS_DATA_WIDTH-1:0] c_hdr0      = C_S_AXIS_DATA_WIDTH'(C_HDR0);
    localparam logic [C_S_AXIS_DATA_WIDTH-1:0] c_hdr1      = C_S_AXIS_DATA_WIDTH'(C_HDR1);
    localparam logic [STRB_W-1:0]              c_last_strb = STRB_W'(C_LAST_TSTRB);
    localparam logic [STRB_W-1:0]              c_strb_ones = '1;
    localparam logic [7:0]                     c_last_beat = 8'(C_PAYLOAD_WORDS - 1);

    logic                           r_tready;
    logic [1:0]                     r_state;
    logic [7:0]                     r_beat;
    logic [31:0]                    r_pkt_count;
    logic [31:0]                    r_err_count;
    logic                           r_err_flag;
    logic [2:0]                     r_err_code;

    logic                           w_xfer;
    logic                           w_check;
    logic                           w_is_last_beat;
    logic [C_S_AXIS_DATA_WIDTH-1:0] w_exp_data;
    logic [STRB_W-1:0]              w_exp_strb;
    logic                           w_data_mis;
    logic [2:0]                     w_code;
    logic                           w_unused;

    assign w_unused = ^s_axis_tuser;

    // ------------------------------------------------------------------------
    // tready generation
    // ------------------------------------------------------------------------
    generate
        if (C_BACKPRESSURE != 0) begin : g_lfsr_ready
            logic [15:0] w_lfsr_q;
            logic        w_lfsr_fb;

            nf10_lfsr16 u_lfsr (
                .clk    (axi_aclk),
                .resetn (axi_resetn),
                .en     (1'b1),
                .q      (w_lfsr_q)
            );

            // Feedback bit is the LFSR's next bit 0; registering it keeps
            // tready equal to q[0] while still forcing 0 during reset.
            assign w_lfsr_fb = ^(w_lfsr_q & c_lfsr_taps);

            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_tready <= 1'b0;
                end else begin
                    r_tready <= w_lfsr_fb;
                end
            end
        end else begin : g_const_ready
            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_tready <= 1'b0;
                end else begin
                    r_tready <= 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Beat checking
    // ------------------------------------------------------------------------
    assign w_xfer         = s_axis_tvalid & r_tready;
    assign w_check        = w_xfer && (r_state != c_st_drop);
    assign w_is_last_beat = (r_state == c_st_payload) && (r_beat == c_last_beat);
    assign w_exp_strb     = w_is_last_beat ? c_last_strb : c_strb_ones;

    always_comb begin
        case (r_state)
            c_st_hdr0: w_exp_data = c_hdr0;
            c_st_hdr1: w_exp_data = c_hdr1;
            default:   w_exp_data = {STRB_W{r_beat}};
        endcase
    end

    // Only strobed bytes take part in the data comparison
    always_comb begin
        w_data_mis = 1'b0;
        for (int i = 0; i < STRB_W; i++) begin
            if (s_axis_tstrb[i] && (s_axis_tdata[8*i +: 8] != w_exp_data[8*i +: 8])) begin
                w_data_mis = 1'b1;
            end
        end
    end

    // Priority order gives the lowest applicable code
    always_comb begin
        if (w_data_mis) begin
            w_code = (r_state == c_st_payload) ? c_err_data : c_err_hdr;
        end else if (s_axis_tstrb != w_exp_strb) begin
            w_code = c_err_strb;
        end else if (s_axis_tlast && !w_is_last_beat) begin
            w_code = c_err_early_last;
        end else if (!s_axis_tlast && w_is_last_beat) begin
            w_code = c_err_missing_last;
        end else begin
            w_code = c_err_none;
        end
    end

    // ------------------------------------------------------------------------
    // Packet state machine and statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state     <= c_st_hdr0;
            r_beat      <= 8'd0;
            r_pkt_count <= 32'd0;
            r_err_count <= 32'd0;
            r_err_flag  <= 1'b0;
            r_err_code  <= c_err_none;
        end else begin
            if (w_xfer) begin
                if (r_state == c_st_drop) begin
                    if (s_axis_tlast) begin
                        r_state <= c_st_hdr0;
                    end
                end else if (w_code != c_err_none) begin
                    r_state <= s_axis_tlast ? c_st_hdr0 : c_st_drop;
                    r_beat  <= 8'd0;
                end else begin
                    case (r_state)
                        c_st_hdr0: r_state <= c_st_hdr1;
                        c_st_hdr1: begin
                            r_state <= c_st_payload;
                            r_beat  <= 8'd0;
                        end
                        default: begin
                            if (w_is_last_beat) begin
                                r_state <= c_st_hdr0;
                                r_beat  <= 8'd0;
                            end else begin
                                r_beat <= r_beat + 8'd1;
                            end
                        end
                    endcase
                end
            end

            // clear_stats overrides any counter update in the same cycle
            if (clear_stats) begin
                r_pkt_count <= 32'd0;
                r_err_count <= 32'd0;
                r_err_flag  <= 1'b0;
            end else begin
                if (w_check && (w_code != c_err_none)) begin
                    if (r_err_count != 32'hFFFF_FFFF) begin
                        r_err_count <= r_err_count + 32'd1;
                    end
                    r_err_flag <= 1'b1;
                end
                if (w_check && (w_code == c_err_none) && w_is_last_beat) begin
                    if (r_pkt_count != 32'hFFFF_FFFF) begin
                        r_pkt_count <= r_pkt_count + 32'd1;
                    end
                end
            end

            if (w_check && (w_code != c_err_none)) begin
                r_err_code <= w_code;
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign pkt_count     = r_pkt_count;
    assign err_count     = r_err_count;
    assign err_flag      = r_err_flag;
    assign err_code      = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_nf10_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nf10_axis_pkt_checker
// Purpose  : Self-checking bench. Two checkers share one stream: dut_bp uses
//            LFSR backpressure, dut_nb always-ready; dut_nb only sees tvalid
//            when dut_bp accepts, so both consume identical beat streams.
//            Expected counts come from a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nf10_axis_pkt_checker;

    localparam int          PW   = 48;
    localparam logic [63:0] HDR0 = 64'hEFBEFECAFECAFECA;
    localparam logic [63:0] HDR1 = 64'h00000008EFBEEFBE;

    logic         clk = 1'b0;
    logic         rstn;
    logic [63:0]  tdata;
    logic [7:0]   tstrb;
    logic [127:0] tuser;
    logic         tvalid, tlast, clear_stats;
    logic         tready_bp, tready_nb, tvalid_nb;
    logic [31:0]  pkt_bp, err_bp, pkt_nb, err_nb;
    logic         flag_bp, flag_nb;
    logic [2:0]   code_bp, code_nb;

    always #5 clk = ~clk;

    assign tvalid_nb = tvalid & tready_bp;

    nf10_axis_pkt_checker #(.C_BACKPRESSURE(1)) dut_bp (
        .axi_aclk(clk), .axi_resetn(rstn), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
        .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready_bp), .clear_stats(clear_stats), .pkt_count(pkt_bp),
        .err_count(err_bp), .err_flag(flag_bp), .err_code(code_bp));

    nf10_axis_pkt_checker #(.C_BACKPRESSURE(0)) dut_nb (
        .axi_aclk(clk), .axi_resetn(rstn), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
        .s_axis_tuser(tuser), .s_axis_tvalid(tvalid_nb), .s_axis_tlast(tlast),
        .s_axis_tready(tready_nb), .clear_stats(clear_stats), .pkt_count(pkt_nb),
        .err_count(err_nb), .err_flag(flag_nb), .err_code(code_nb));

    int          checks = 0;
    int          failures = 0;
    int          stalls = 0;
    int          toggles = 0;
    logic        prev_tready = 1'b0;
    bit          gaps = 1'b1;

    int unsigned exp_pkt = 0;
    int unsigned exp_err = 0;
    logic        exp_flag = 1'b0;
    logic [2:0]  exp_code = 3'd0;

    logic [63:0] f_data[$];
    logic [7:0]  f_strb[$];
    logic        f_last[$];

    always @(posedge clk) begin
        if (rstn) begin
            if (tready_bp !== prev_tready) toggles <= toggles + 1;
            prev_tready <= tready_bp;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_good();
        logic [7:0]  b;
        logic [63:0] d;
        f_data.delete(); f_strb.delete(); f_last.delete();
        f_data.push_back(HDR0); f_strb.push_back(8'hFF); f_last.push_back(1'b0);
        f_data.push_back(HDR1); f_strb.push_back(8'hFF); f_last.push_back(1'b0);
        for (int p = 0; p < PW; p++) begin
            b = 8'(p);
            d = {8{b}};
            if (p == PW - 1) begin
                d[63:48] = 16'($urandom);   // unstrobed bytes must be ignored
                f_strb.push_back(8'h3F); f_last.push_back(1'b1);
            end else begin
                f_strb.push_back(8'hFF); f_last.push_back(1'b0);
            end
            f_data.push_back(d);
        end
    endtask

    task automatic truncate_at(input int idx);
        f_last[idx] = 1'b1;
        while (f_data.size() > idx + 1) begin
            void'(f_data.pop_back()); void'(f_strb.pop_back()); void'(f_last.pop_back());
        end
    endtask

    task automatic drop_last_tlast();
        f_last[PW+1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            f_data.push_back({$urandom, $urandom});
            f_strb.push_back(8'hFF);
            f_last.push_back(k == 2);
        end
    endtask

    // Packet-level verdict: walk beats against the expected layout, first
    // failing beat decides; the rest of the frame is discarded up to its tlast.
    task automatic model_frame(output logic err, output logic [2:0] code);
        logic [63:0] ed;
        logic [7:0]  es, pb;
        logic        el;
        bit          dm;
        int          c;
        err = 1'b0; code = 3'd0;
        for (int i = 0; i < f_data.size(); i++) begin
            pb = 8'(i - 2);
            if (i == 0) ed = HDR0; else if (i == 1) ed = HDR1; else ed = {8{pb}};
            el = (i == PW + 1);
            es = el ? 8'h3F : 8'hFF;
            dm = 1'b0;
            for (int j = 0; j < 8; j++)
                if (f_strb[i][j] && (f_data[i][8*j +: 8] != ed[8*j +: 8])) dm = 1'b1;
            c = 0;
            if (dm) c = (i < 2) ? 1 : 2;
            else if (f_strb[i] != es) c = 3;
            else if (f_last[i] && !el) c = 4;
            else if (!f_last[i] && el) c = 5;
            if (c != 0) begin err = 1'b1; code = 3'(c); return; end
            if (el) return;
        end
    endtask

    task automatic model_apply(input bit clr);
        logic err;
        logic [2:0] code;
        model_frame(err, code);
        if (err) exp_code = code;
        if (clr) begin
            exp_pkt = 0; exp_err = 0; exp_flag = 1'b0;
        end else if (err) begin
            exp_err++; exp_flag = 1'b1;
        end else begin
            exp_pkt++;
        end
    endtask

    // Entered and left at posedge+1
    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input bit clr);
        bit ok = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            tvalid = 1'b0; tdata = {$urandom, $urandom}; tstrb = 8'($urandom); tlast = 1'($urandom);
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            ok = tready_bp;
            if (!ok) stalls++;
            if (ok && clr) clear_stats = 1'b1;
            @(posedge clk); #1;
            clear_stats = 1'b0;
            if (ok) break;
        end
        if (!ok) begin
            checks++; failures++;
            $error("FAIL beat_accept observed=stalled expected=accepted");
        end
    endtask

    task automatic send_frame(input bit clr_on_last);
        for (int i = 0; i < f_data.size(); i++)
            send_beat(f_data[i], f_strb[i], f_last[i], clr_on_last && (i == f_data.size() - 1));
    endtask

    task automatic run_frame(input bit clr);
        model_apply(clr);
        send_frame(clr);
        tvalid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        tvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_pkt_bp"},  pkt_bp,  exp_pkt);
        chk({tag, "_err_bp"},  err_bp,  exp_err);
        chk({tag, "_flag_bp"}, 32'(flag_bp), 32'(exp_flag));
        chk({tag, "_code_bp"}, 32'(code_bp), 32'(exp_code));
        chk({tag, "_pkt_nb"},  pkt_nb,  exp_pkt);
        chk({tag, "_err_nb"},  err_nb,  exp_err);
        chk({tag, "_flag_nb"}, 32'(flag_nb), 32'(exp_flag));
        chk({tag, "_code_nb"}, 32'(code_nb), 32'(exp_code));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tready_bp"}, 32'(tready_bp), 32'd0);
        chk({tag, "_tready_nb"}, 32'(tready_nb), 32'd0);
        chk({tag, "_pkt"},  pkt_bp, 32'd0);
        chk({tag, "_err"},  err_bp, 32'd0);
        chk({tag, "_flag"}, 32'(flag_bp), 32'd0);
        chk({tag, "_code"}, 32'(code_bp), 32'd0);
    endtask

    initial begin
        int kind, idx, t0, s0;
        rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0; clear_stats = 1'b0;
        tdata = '0; tstrb = '0; tuser = {4{$urandom}};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("nb_tready_after_reset", 32'(tready_nb), 32'd1);

        // Good packet
        build_good(); run_frame(1'b0); check_all("good");

        // Payload beat 5 corrupted, then a good packet
        build_good(); f_data[2+5] = 64'h0505050505050506; run_frame(1'b0); check_all("data_err");
        chk("data_err_code_is_2", 32'(code_bp), 32'd2);
        build_good(); run_frame(1'b0); check_all("after_data_err");

        // Early tlast on payload beat 10, then a good packet
        build_good(); truncate_at(2 + 10); run_frame(1'b0); check_all("early_tlast");
        chk("early_tlast_code_is_4", 32'(code_bp), 32'd4);
        build_good(); run_frame(1'b0); check_all("after_early_tlast");

        // Missing tlast on last beat, three fillers, then a good packet
        build_good(); drop_last_tlast(); run_frame(1'b0); check_all("missing_tlast");
        chk("missing_tlast_code_is_5", 32'(code_bp), 32'd5);
        build_good(); run_frame(1'b0); check_all("after_missing_tlast");

        // Header corruption
        build_good(); f_data[1] = f_data[1] ^ 64'h0000_0100_0000_0000; run_frame(1'b0); check_all("hdr_err");

        // clear_stats in the same cycle as a final good beat
        build_good(); run_frame(1'b1); check_all("clear_on_last");
        build_good(); run_frame(1'b0); check_all("after_clear");

        // Reset in the middle of a packet
        build_good();
        for (int i = 0; i < 20; i++) send_beat(f_data[i], f_strb[i], f_last[i], 1'b0);
        @(negedge clk); rstn = 1'b0;
        exp_pkt = 0; exp_err = 0; exp_flag = 1'b0; exp_code = 3'd0;
        @(negedge clk);
        check_reset_values("midpkt_reset");
        rstn = 1'b1; tvalid = 1'b0;
        @(posedge clk); #1;
        build_good(); run_frame(1'b0); check_all("after_midpkt_reset");

        // Randomized packet mix
        for (int n = 0; n < 40; n++) begin
            build_good();
            kind = $urandom_range(0, 5);
            case (kind)
                1: begin idx = $urandom_range(2, PW + 1); f_data[idx] = f_data[idx] ^ (64'd1 << $urandom_range(0, 7)); end
                2: begin idx = $urandom_range(0, PW + 1); f_strb[idx] = f_strb[idx] ^ (8'd1 << $urandom_range(0, 7)); end
                3: truncate_at($urandom_range(0, PW));
                4: drop_last_tlast();
                5: begin idx = $urandom_range(0, 1); f_data[idx] = f_data[idx] ^ (64'd1 << $urandom_range(0, 63)); end
                default: ;
            endcase
            run_frame(1'b0);
            check_all($sformatf("rand%0d_k%0d", n, kind));
        end

        // 100 back-to-back good packets, tvalid held high
        build_good(); run_frame(1'b1); check_all("pre_burst_clear");
        gaps = 1'b0; t0 = toggles; s0 = stalls;
        for (int n = 0; n < 100; n++) begin
            build_good(); model_apply(1'b0); send_frame(1'b0);
        end
        check_all("burst100");
        chk("burst_pkt_count_100", pkt_bp, 32'd100);
        chk("burst_tready_toggles", 32'(toggles > t0 + 10), 32'd1);
        chk("burst_stalls_seen", 32'(stalls > s0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
